// File: rtl/ppg_pkg.sv
// ppg_pkg: shared types and widths for the PPG LED/ADC/FIR channel scheduler.
//   ADC_W   - ADC conversion result width
//   FIR_W   - FIR result / filtered output width
//   state_t - scheduler FSM states
//   chan_t  - LED channel / FIR bank select (IR=0, Red=1)
package ppg_pkg;

    localparam int ADC_W = 8;
    localparam int FIR_W = 20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        FILTER = 3'd3,
        HOLD   = 3'd4,
        GAP    = 3'd5
    } state_t;

    typedef enum logic {
        CH_IR  = 1'b0,
        CH_RED = 1'b1
    } chan_t;

endpackage

// File: rtl/slot_timer.sv
// slot_timer: free-running slot counter, 0..SLOT_CYCLES-1 with wrap.
//   clk      - clock
//   rst_n    - async active-low reset
//   clear    - hold count at 0 (scheduler idle or leaving run)
//   count    - current position in the slot
//   slot_end - high on the wrap cycle (count = SLOT_CYCLES-1)
module slot_timer #(
    parameter int SLOT_CYCLES = 2500,
    parameter int CNT_W       = $clog2(SLOT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             slot_end
);

    assign slot_end = (count == CNT_W'(SLOT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || slot_end) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: alternates Red/IR LED slots, triggers the ADC after
// the LED has settled, hands each sample to a shared FIR datapath and latches
// the per-channel filtered result.
//   CLK_Filter, rst_n              - clock, async active-low reset
//   enable                         - run request (level)
//   LED_Red, LED_IR                - LED drives, never both on
//   adc_start / adc_done, ADC_Value - ADC handshake
//   fir_sample, fir_valid, fir_ch_sel / fir_result, fir_done - FIR handshake
//   Out_Red_Filtered, Out_IR_Filtered, red_valid, ir_valid - filtered outputs
//   overrun                        - sticky: a slot ended before its work finished
//
// state  | meaning
// IDLE   | LEDs off, counter 0, channel Red; waits for enable
// SETTLE | active LED on, waiting for the photodiode to settle
// SAMPLE | ADC conversion in flight
// FILTER | FIR computation in flight
// HOLD   | result captured, waiting for slot end
// GAP    | one cycle with both LEDs off, channel swaps on exit
module fir_channel_scheduler
    import ppg_pkg::*;
#(
    parameter int SLOT_CYCLES   = 2500,
    parameter int SETTLE_CYCLES = 500
) (
    input  logic             CLK_Filter,
    input  logic             rst_n,
    input  logic             enable,
    output logic             LED_Red,
    output logic             LED_IR,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] ADC_Value,
    output logic [ADC_W-1:0] fir_sample,
    output logic             fir_valid,
    output logic             fir_ch_sel,
    input  logic [FIR_W-1:0] fir_result,
    input  logic             fir_done,
    output logic [FIR_W-1:0] Out_Red_Filtered,
    output logic [FIR_W-1:0] Out_IR_Filtered,
    output logic             red_valid,
    output logic             ir_valid,
    output logic             overrun
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);

    state_t           state;
    state_t           state_next;
    chan_t            channel;
    logic [CNT_W-1:0] count;
    logic             slot_end;
    logic             timer_clear;
    logic             settle_done;
    logic             led_on;
    logic             launch;
    logic             capture;
    logic             overrun_set;

    // Counter sits at 0 in IDLE so the first SETTLE after enable starts at 0.
    assign timer_clear = (state == IDLE) || !enable;
    assign settle_done = (count == CNT_W'(SETTLE_CYCLES - 1));

    slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_slot_timer (
        .clk      (CLK_Filter),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .count    (count),
        .slot_end (slot_end)
    );

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            channel <= CH_RED;
        end else begin
            state <= state_next;
            if (state_next == IDLE) begin
                channel <= CH_RED;
            end else if (state == GAP) begin
                channel <= (channel == CH_RED) ? CH_IR : CH_RED;
            end
        end
    end

    // Priority: enable drop, then slot end, then the handshake strobes.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = SETTLE;
                SETTLE:  if (slot_end)         state_next = GAP;
                         else if (settle_done) state_next = SAMPLE;
                SAMPLE:  if (slot_end)         state_next = GAP;
                         else if (adc_done)    state_next = FILTER;
                FILTER:  if (slot_end)         state_next = GAP;
                         else if (fir_done)    state_next = HOLD;
                HOLD:    if (slot_end)         state_next = GAP;
                GAP:     state_next = SETTLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        led_on      = 1'b0;
        adc_start   = 1'b0;
        launch      = 1'b0;
        capture     = 1'b0;
        overrun_set = 1'b0;
        case (state)
            SETTLE, SAMPLE, FILTER, HOLD: led_on = 1'b1;
            default:                      led_on = 1'b0;
        endcase
        adc_start   = (state == SETTLE) && (state_next == SAMPLE);
        launch      = (state == SAMPLE) && (state_next == FILTER);
        capture     = (state == FILTER) && (state_next == HOLD);
        overrun_set = ((state == SETTLE) || (state == SAMPLE) || (state == FILTER))
                      && (state_next == GAP);
    end

    // LED drive derives from a single channel bit, so both can never be on.
    assign LED_Red = led_on && (channel == CH_RED);
    assign LED_IR  = led_on && (channel == CH_IR);

    // fir_ch_sel only changes on a launch, so it stays stable through fir_done.
    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            fir_sample       <= '0;
            fir_valid        <= 1'b0;
            fir_ch_sel       <= 1'b0;
            Out_Red_Filtered <= '0;
            Out_IR_Filtered  <= '0;
            red_valid        <= 1'b0;
            ir_valid         <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            fir_valid <= launch;
            red_valid <= capture && (channel == CH_RED);
            ir_valid  <= capture && (channel == CH_IR);
            if (launch) begin
                fir_sample <= ADC_Value;
                fir_ch_sel <= (channel == CH_RED);
            end
            if (capture && (channel == CH_RED)) begin
                Out_Red_Filtered <= fir_result;
            end
            if (capture && (channel == CH_IR)) begin
                Out_IR_Filtered <= fir_result;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// tb_fir_channel_scheduler: directed bench with scoreboard queues for the
// FIR launch and the filtered-result strobes (SLOT_CYCLES=20, SETTLE_CYCLES=4).
module tb_fir_channel_scheduler;
    import ppg_pkg::*;

    localparam int SLOT   = 20;
    localparam int SETTLE = 4;

    logic        CLK_Filter;
    logic        rst_n;
    logic        enable;
    logic        LED_Red;
    logic        LED_IR;
    logic        adc_start;
    logic        adc_done;
    logic [7:0]  ADC_Value;
    logic [7:0]  fir_sample;
    logic        fir_valid;
    logic        fir_ch_sel;
    logic [19:0] fir_result;
    logic        fir_done;
    logic [19:0] Out_Red_Filtered;
    logic [19:0] Out_IR_Filtered;
    logic        red_valid;
    logic        ir_valid;
    logic        overrun;

    fir_channel_scheduler #(
        .SLOT_CYCLES   (SLOT),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .CLK_Filter       (CLK_Filter),
        .rst_n            (rst_n),
        .enable           (enable),
        .LED_Red          (LED_Red),
        .LED_IR           (LED_IR),
        .adc_start        (adc_start),
        .adc_done         (adc_done),
        .ADC_Value        (ADC_Value),
        .fir_sample       (fir_sample),
        .fir_valid        (fir_valid),
        .fir_ch_sel       (fir_ch_sel),
        .fir_result       (fir_result),
        .fir_done         (fir_done),
        .Out_Red_Filtered (Out_Red_Filtered),
        .Out_IR_Filtered  (Out_IR_Filtered),
        .red_valid        (red_valid),
        .ir_valid         (ir_valid),
        .overrun          (overrun)
    );

    typedef struct {
        logic        ch;
        logic [19:0] val;
    } exp_t;

    exp_t        q_fir[$];
    exp_t        q_res[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [19:0] last_red = '0;
    logic [19:0] last_ir  = '0;
    logic        pending  = 1'b0;
    logic        held_sel = 1'b0;

    initial begin
        CLK_Filter = 1'b0;
        forever #5 CLK_Filter = ~CLK_Filter;
    end

    always @(posedge CLK_Filter) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Always-on properties: LED exclusivity and FIR bank select stability.
    always @(negedge CLK_Filter) begin
        check("led_exclusive", 32'(LED_Red & LED_IR), 32'd0);
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            if (pending) check("fir_ch_sel_stable", 32'(fir_ch_sel), 32'(held_sel));
            if (fir_valid === 1'b1) begin
                pending  = 1'b1;
                held_sel = fir_ch_sel;
            end
            if (fir_done === 1'b1 || enable === 1'b0) pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK_Filter);
        #1;
    endtask

    // which: 0 adc_start, 1 fir_valid, 2 red_valid/ir_valid
    task automatic wait_strobe(input int which, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i <= budget && !hit; i++) begin
            if (i > 0) tick();
            case (which)
                0:       hit = (adc_start === 1'b1);
                1:       hit = (fir_valid === 1'b1);
                default: hit = (red_valid === 1'b1) || (ir_valid === 1'b1);
            endcase
        end
        check({tag, "_timeout"}, 32'(hit), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_led_red"},   32'(LED_Red),          32'd0);
        check({tag, "_led_ir"},    32'(LED_IR),           32'd0);
        check({tag, "_adc_start"}, 32'(adc_start),        32'd0);
        check({tag, "_fir_valid"}, 32'(fir_valid),        32'd0);
        check({tag, "_fir_smp"},   32'(fir_sample),       32'd0);
        check({tag, "_fir_sel"},   32'(fir_ch_sel),       32'd0);
        check({tag, "_out_red"},   32'(Out_Red_Filtered), 32'd0);
        check({tag, "_out_ir"},    32'(Out_IR_Filtered),  32'd0);
        check({tag, "_red_vld"},   32'(red_valid),        32'd0);
        check({tag, "_ir_vld"},    32'(ir_valid),         32'd0);
        check({tag, "_overrun"},   32'(overrun),          32'd0);
    endtask

    // ADC answers 2 cycles after adc_start.
    task automatic answer_adc(input logic ch, input logic [7:0] v);
        exp_t e;
        wait_strobe(0, SLOT + 5, "adc_start");
        check("slot_led_red", 32'(LED_Red), 32'(ch));
        check("slot_led_ir",  32'(LED_IR),  32'(!ch));
        tick();
        tick();
        adc_done  = 1'b1;
        ADC_Value = v;
        e.ch  = ch;
        e.val = 20'(v);
        q_fir.push_back(e);
        tick();
        adc_done  = 1'b0;
        ADC_Value = 8'h00;
    endtask

    task automatic check_fir();
        exp_t e;
        wait_strobe(1, 4, "fir_valid");
        if (q_fir.size() == 0) begin
            check("fir_sb_empty", 32'd0, 32'd1);
        end else begin
            e = q_fir.pop_front();
            check("fir_sample", 32'(fir_sample), 32'(e.val));
            check("fir_ch_sel", 32'(fir_ch_sel), 32'(e.ch));
        end
    endtask

    // FIR answers 3 cycles after fir_valid with sample*128.
    task automatic finish_filter(input logic ch, input logic [7:0] v);
        exp_t e;
        e.ch  = ch;
        e.val = 20'(v) << 7;
        q_res.push_back(e);
        tick();
        tick();
        tick();
        fir_done   = 1'b1;
        fir_result = e.val;
        tick();
        fir_done   = 1'b0;
        fir_result = 20'h0;
        wait_strobe(2, 3, "result");
        if (q_res.size() == 0) begin
            check("res_sb_empty", 32'd0, 32'd1);
        end else begin
            e = q_res.pop_front();
            check("red_valid", 32'(red_valid), 32'(e.ch));
            check("ir_valid",  32'(ir_valid),  32'(!e.ch));
            check("out_value", 32'(e.ch ? Out_Red_Filtered : Out_IR_Filtered), 32'(e.val));
            if (e.ch) last_red = e.val;
            else      last_ir  = e.val;
        end
    endtask

    task automatic run_slot(input logic ch, input logic [7:0] v);
        answer_adc(ch, v);
        check_fir();
        finish_filter(ch, v);
    endtask

    task automatic wait_gap(input logic next_ch, output int gcyc);
        bit hit;
        hit  = 1'b0;
        gcyc = 0;
        for (int i = 0; i < SLOT + 5 && !hit; i++) begin
            tick();
            hit = (LED_Red === 1'b0) && (LED_IR === 1'b0);
        end
        check("gap_timeout", 32'(hit), 32'd1);
        gcyc = cyc;
        tick();
        check("post_gap_red", 32'(LED_Red), 32'(next_ch));
        check("post_gap_ir",  32'(LED_IR),  32'(!next_ch));
    endtask

    initial begin
        int g1, g2, g3;
        rst_n      = 1'b0;
        enable     = 1'b0;
        adc_done   = 1'b0;
        ADC_Value  = 8'h00;
        fir_done   = 1'b0;
        fir_result = 20'h0;
        tick();
        tick();
        check_all_zero("reset");
        check("reset_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_led_red", 32'(LED_Red), 32'd0);

        // Normal alternating operation.
        enable = 1'b1;
        run_slot(1'b1, 8'h40);
        check("red_0x02000", 32'(Out_Red_Filtered), 32'h02000);
        wait_gap(1'b0, g1);
        run_slot(1'b0, 8'h80);
        check("ir_0x04000", 32'(Out_IR_Filtered), 32'h04000);
        wait_gap(1'b1, g2);
        check("gap_period_a", 32'(g2 - g1), 32'(SLOT));

        // Spurious adc_done in SETTLE, then spurious fir_done in HOLD.
        adc_done  = 1'b1;
        ADC_Value = 8'hAA;
        tick();
        adc_done  = 1'b0;
        ADC_Value = 8'h00;
        check("spur_adc_fir_valid", 32'(fir_valid), 32'd0);
        run_slot(1'b1, 8'h41);
        fir_done   = 1'b1;
        fir_result = 20'hFFFFF;
        tick();
        fir_done   = 1'b0;
        fir_result = 20'h0;
        check("spur_fir_red_vld", 32'(red_valid), 32'd0);
        check("spur_fir_ir_vld",  32'(ir_valid),  32'd0);
        check("spur_fir_out_red", 32'(Out_Red_Filtered), 32'(last_red));
        check("spur_fir_out_ir",  32'(Out_IR_Filtered),  32'(last_ir));
        wait_gap(1'b0, g3);
        check("gap_period_b", 32'(g3 - g2), 32'(SLOT));
        check("no_overrun_yet", 32'(overrun), 32'd0);

        // Overrun: withhold adc_done in the Red slot.
        enable = 1'b0;
        tick();
        check("disable_led_ir", 32'(LED_IR), 32'd0);
        enable = 1'b1;
        wait_strobe(0, SLOT + 5, "ovr_adc_start");
        check("ovr_red_slot", 32'(LED_Red), 32'd1);
        check("ovr_before", 32'(overrun), 32'd0);
        wait_gap(1'b0, g1);
        check("ovr_set", 32'(overrun), 32'd1);
        adc_done  = 1'b1;
        ADC_Value = 8'h33;
        tick();
        adc_done  = 1'b0;
        ADC_Value = 8'h00;
        check("late_adc_fir_valid", 32'(fir_valid), 32'd0);
        run_slot(1'b0, 8'h7F);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_out_red_held", 32'(Out_Red_Filtered), 32'(last_red));

        // Drop enable during FILTER; later fir_done must be ignored.
        wait_gap(1'b1, g2);
        answer_adc(1'b1, 8'h55);
        check_fir();
        enable = 1'b0;
        tick();
        check("abort_led_red", 32'(LED_Red), 32'd0);
        check("abort_led_ir",  32'(LED_IR),  32'd0);
        check("abort_state",   32'(dut.state), 32'(IDLE));
        tick();
        fir_done   = 1'b1;
        fir_result = 20'h12345;
        tick();
        fir_done   = 1'b0;
        fir_result = 20'h0;
        check("abort_red_vld", 32'(red_valid), 32'd0);
        check("abort_ir_vld",  32'(ir_valid),  32'd0);
        check("abort_out_red", 32'(Out_Red_Filtered), 32'(last_red));
        check("abort_out_ir",  32'(Out_IR_Filtered),  32'(last_ir));
        check("abort_overrun", 32'(overrun), 32'd1);

        // Asynchronous reset during SAMPLE.
        enable = 1'b1;
        wait_strobe(0, SLOT + 5, "rst_adc_start");
        tick();
        check("rst_in_sample", 32'(dut.state), 32'(SAMPLE));
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        check("async_rst_state", 32'(dut.state), 32'(IDLE));
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_led_red", 32'(LED_Red), 32'd0);

        check("fir_sb_drained", 32'(q_fir.size()), 32'd0);
        check("res_sb_drained", 32'(q_res.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
